systolic_tile_ctrl: RTL and testbench

Parametrised successor to the fixed 16x16 systolic-array controller. It sequences a K-dimension-tiled matrix multiply over a ROWS x COLS array with a runtime K length. For each tile it loads operand beats from the buffer with a stall-tolerant handshake, issues skewed per-row and per-column valids, then drains the array. It sits between the operand buffers and the PE array, and reports per-tile and job completion to the top-level sequencer.

---
 rtl/systolic_tile_ctrl_if.sv | 54 +++++
 rtl/systolic_tile_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_tile_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_tile_ctrl_if
//
// Job / load / array-valid bundle between the top-level sequencer plus
// operand buffer (master side) and the systolic tile controller (slave side).
//
// Handshake: the buffer raises data_valid when a beat is available and the
// controller raises rd_req while it still wants beats for the current tile.
// A beat transfers on every clock edge where rd_req && data_valid are both
// high. Neither side may wait for the other before asserting its own signal,
// and data_valid may drop at any time.
//
// Signals:
//   start, k_len, abort  : job control from the sequencer
//   data_valid           : buffer has a beat available
//   rd_req               : controller wants a beat for the current tile
//   valid_a / valid_b    : skewed per-row / per-column operand valids
//   acc_clr              : one-cycle accumulator clear at job start
//   tile_done, done      : one-cycle completion pulses
//   tile_idx, busy       : job progress
//   state_dbg            : encoded controller state, for observation only
// ---------------------------------------------------------------------------
interface systolic_tile_ctrl_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int KW   = 16,
    parameter int TW   = 8
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic            abort;
    logic            data_valid;
    logic            rd_req;
    logic [ROWS-1:0] valid_a;
    logic [COLS-1:0] valid_b;
    logic            acc_clr;
    logic            tile_done;
    logic [TW-1:0]   tile_idx;
    logic            busy;
    logic            done;
    logic [2:0]      state_dbg;

    modport master (
        output start, k_len, abort, data_valid,
        input  rd_req, valid_a, valid_b, acc_clr, tile_done, tile_idx,
               busy, done, state_dbg
    );

    modport slave (
        input  start, k_len, abort, data_valid,
        output rd_req, valid_a, valid_b, acc_clr, tile_done, tile_idx,
               busy, done, state_dbg
    );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_tile_ctrl
//
// Sequences a K-tiled matrix multiply over a ROWS x COLS systolic array.
// A job of k_len beats is split into tiles of at most BUF_DEPTH beats. For
// each tile the controller loads its beats from the operand buffer, then
// issues skewed per-row / per-column valids for tile_len + max(ROWS,COLS) - 1
// cycles, then drains the array for ROWS + COLS - 1 cycles. Accumulators
// are cleared once per job so partial products accumulate across tiles.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : systolic_tile_ctrl_if.slave (job control, load handshake,
//            array valids, completion pulses, state_dbg)
// ---------------------------------------------------------------------------
module systolic_tile_ctrl #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int BUF_DEPTH = 9,
    parameter int KW        = 16,
    parameter int TW        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_tile_ctrl_if.slave  bus
);
    localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
    localparam int LW    = $clog2(BUF_DEPTH + 1);
    // Wide enough for the last compute index plus the lane offset.
    localparam int CW    = $clog2(BUF_DEPTH + ROWS + COLS + 1);

    localparam logic [KW-1:0] BD_K       = KW'(BUF_DEPTH);
    localparam logic [CW-1:0] COMP_EXTRA = CW'(MAXRC - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state;
    // Beats of the job not yet covered by finished tiles (includes current).
    logic [KW-1:0]   rem;
    logic [LW-1:0]   ld_cnt;
    // Cycle index c in COMPUTE, drain cycle index in DRAIN.
    logic [CW-1:0]   cyc_cnt;
    logic [ROWS-1:0] valid_a_q;
    logic [COLS-1:0] valid_b_q;
    logic            acc_clr_q;
    logic            tile_done_q;
    logic [TW-1:0]   tile_idx_q;
    logic            busy_q;
    logic            done_q;

    logic [LW-1:0]    tile_len;
    logic             last_tile;
    logic             rd_req;
    logic             xfer;
    logic             ld_last;
    logic             comp_last;
    logic [MAXRC-1:0] mask_first;
    logic [MAXRC-1:0] mask_next;

    // Lane i is active for c in [i, i + len): the diagonal skew of the array.
    function automatic logic [MAXRC-1:0] lane_mask(input logic [CW-1:0] c,
                                                   input logic [LW-1:0] len);
        logic [MAXRC-1:0] m;
        m = '0;
        for (int i = 0; i < MAXRC; i++) begin
            m[i] = (CW'(i) <= c) && (c < CW'(i) + CW'(len));
        end
        return m;
    endfunction

    // Every tile is full except the last, which takes whatever remains.
    assign tile_len  = (rem >= BD_K) ? LW'(BUF_DEPTH) : rem[LW-1:0];
    assign last_tile = (rem <= BD_K);

    assign rd_req    = (state == S_LOAD) && (ld_cnt < tile_len);
    assign xfer      = rd_req && bus.data_valid;
    assign ld_last   = xfer && ((ld_cnt + LW'(1)) == tile_len);
    assign comp_last = (cyc_cnt + CW'(1)) == (CW'(tile_len) + COMP_EXTRA);

    assign mask_first = lane_mask('0, tile_len);
    assign mask_next  = lane_mask(cyc_cnt + CW'(1), tile_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rem         <= '0;
            ld_cnt      <= '0;
            cyc_cnt     <= '0;
            valid_a_q   <= '0;
            valid_b_q   <= '0;
            acc_clr_q   <= 1'b0;
            tile_done_q <= 1'b0;
            tile_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acc_clr_q   <= 1'b0;
            tile_done_q <= 1'b0;
            done_q      <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state      <= S_IDLE;
                rem        <= '0;
                ld_cnt     <= '0;
                cyc_cnt    <= '0;
                valid_a_q  <= '0;
                valid_b_q  <= '0;
                tile_idx_q <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            acc_clr_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            tile_idx_q <= '0;
                            ld_cnt     <= '0;
                            cyc_cnt    <= '0;
                            rem        <= bus.k_len;
                            if (bus.k_len == '0) begin
                                // Empty job: clear and complete in one cycle.
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                state  <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (ld_last) begin
                            ld_cnt    <= '0;
                            cyc_cnt   <= '0;
                            valid_a_q <= mask_first[ROWS-1:0];
                            valid_b_q <= mask_first[COLS-1:0];
                            state     <= S_COMPUTE;
                        end else if (xfer) begin
                            ld_cnt <= ld_cnt + LW'(1);
                        end
                    end
                    S_COMPUTE: begin
                        if (comp_last) begin
                            valid_a_q   <= '0;
                            valid_b_q   <= '0;
                            cyc_cnt     <= '0;
                            // A one-cycle drain is also its last cycle.
                            tile_done_q <= (DRAIN_LAST == '0);
                            state       <= S_DRAIN;
                        end else begin
                            cyc_cnt   <= cyc_cnt + CW'(1);
                            valid_a_q <= mask_next[ROWS-1:0];
                            valid_b_q <= mask_next[COLS-1:0];
                        end
                    end
                    S_DRAIN: begin
                        if (cyc_cnt == DRAIN_LAST) begin
                            cyc_cnt <= '0;
                            if (last_tile) begin
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                rem        <= rem - BD_K;
                                tile_idx_q <= tile_idx_q + TW'(1);
                                state      <= S_LOAD;
                            end
                        end else begin
                            cyc_cnt     <= cyc_cnt + CW'(1);
                            tile_done_q <= ((cyc_cnt + CW'(1)) == DRAIN_LAST);
                        end
                    end
                    S_DONE: begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rd_req    = rd_req;
    assign bus.valid_a   = valid_a_q;
    assign bus.valid_b   = valid_b_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.tile_done = tile_done_q;
    assign bus.tile_idx  = tile_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_tile_ctrl
//
// Two controllers: unit 0 with default geometry (16x16, BUF_DEPTH 9) and
// unit 1 with a non-square array (4x8, BUF_DEPTH 4). Directed jobs push
// hand-computed expected events into per-unit queues; a negedge monitor
// condenses the DUT outputs into events (acc_clr, per-tile summary, done,
// busy falling, reset entry) and compares them in order.
// ---------------------------------------------------------------------------
module tb_systolic_tile_ctrl;
    localparam int W = 84;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_tile_ctrl_if #(.ROWS(16), .COLS(16), .KW(16), .TW(8)) bus0 ();
    systolic_tile_ctrl_if #(.ROWS(4),  .COLS(8),  .KW(16), .TW(8)) bus1 ();

    systolic_tile_ctrl #(.ROWS(16), .COLS(16), .BUF_DEPTH(9), .KW(16), .TW(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    systolic_tile_ctrl #(.ROWS(4), .COLS(8), .BUF_DEPTH(4), .KW(16), .TW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // ---------------- event encoding ----------------
    function automatic logic [W-1:0] ev(input int kind, input int f0, input int f1,
                                        input int f2, input int f3, input int f4,
                                        input int f5, input int f6, input int f7,
                                        input int f8, input int f9);
        return {4'(kind), 8'(f0), 8'(f1), 8'(f2), 8'(f3), 8'(f4),
                8'(f5), 8'(f6), 8'(f7), 8'(f8), 8'(f9)};
    endfunction

    task automatic push(input int u, input logic [W-1:0] e);
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // kind 1: acc_clr {busy, tile_idx}
    task automatic exp_acc(input int u);
        push(u, ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask
    // kind 2: tile_done {idx, beats, compute cycles, drain cycles, load->valid
    //   latency, first/last c of last row lane, its high count, last c of
    //   row 0, last c of last column lane}
    task automatic exp_tile(input int u, input int idx, input int ld, input int comp,
                            input int dr, input int af, input int al, input int ac,
                            input int a0l, input int bl);
        push(u, ev(2, idx, ld, comp, dr, 1, af, al, ac, a0l, bl));
    endtask
    // kind 3: done {busy, tile_idx, tiles seen, beats since last tile, any valid, acc_clr}
    task automatic exp_done(input int u, input int tidx, input int ntiles, input int acc);
        push(u, ev(3, 1, tidx, ntiles, 0, 0, acc, 0, 0, 0, 0));
    endtask
    // kind 4: busy fell {any valid, rd_req, tile_done, done, c at that cycle, tile_idx}
    task automatic exp_idle(input int u, input int c, input int tidx);
        push(u, ev(4, 0, 0, 0, 0, c, tidx, 0, 0, 0, 0));
    endtask
    // kind 5: reset seen {busy, rd_req, any valid, acc_clr, tile_done, done, tile_idx, state}
    task automatic exp_rst(input int u);
        push(u, ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check(input int u, input logic [W-1:0] got, input string nm);
        logic [W-1:0] e;
        n_tests++;
        if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
            n_fail++;
            $display("FAIL %s u%0d: unexpected event got=%h required=none", nm, u, got);
            return;
        end
        e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s u%0d: got=%h required=%h", nm, u, got, e);
        end
    endtask

    // ---------------- monitor ----------------
    int m_xfer[2], m_last_xfer[2], m_cyc[2], m_c[2], m_comp[2], m_drain[2];
    int m_lat[2], m_af[2], m_al[2], m_ac[2], m_a0l[2], m_bl[2], m_ntiles[2];
    bit m_started[2], m_prev_busy[2], m_in_rst[2];

    task automatic clear_tile(input int u);
        m_xfer[u] = 0; m_started[u] = 0; m_c[u] = 0; m_comp[u] = 0; m_drain[u] = 0;
        m_lat[u] = 0; m_af[u] = 0; m_al[u] = 0; m_ac[u] = 0; m_a0l[u] = 0; m_bl[u] = 0;
    endtask

    task automatic observe(input int u, input logic busy, input logic rd, input logic dv,
                           input logic acc, input logic td, input logic dn,
                           input logic [15:0] va, input logic [15:0] vb,
                           input logic [7:0] tidx, input logic [2:0] st,
                           input int r, input int c);
        logic anyv;
        anyv = (|va) || (|vb);
        if (!rst_n) begin
            if (!m_in_rst[u]) begin
                check(u, ev(5, busy, rd, anyv, acc, td, dn, tidx, st, 0, 0), "reset");
                m_in_rst[u] = 1;
            end
            clear_tile(u);
            m_ntiles[u] = 0;
            m_prev_busy[u] = 0;
            return;
        end
        m_in_rst[u] = 0;
        if (acc) begin
            check(u, ev(1, busy, tidx, 0, 0, 0, 0, 0, 0, 0, 0), "acc_clr");
            m_ntiles[u] = 0;
            clear_tile(u);
        end
        if (rd && dv) begin
            m_xfer[u]++;
            m_last_xfer[u] = m_cyc[u];
        end
        if (anyv && !m_started[u]) begin
            m_started[u] = 1;
            m_c[u] = 0;
            m_lat[u] = m_cyc[u] - m_last_xfer[u];
        end
        if (m_started[u]) begin
            if (anyv) begin
                m_comp[u]++;
                if (va[r-1]) begin
                    if (m_ac[u] == 0) m_af[u] = m_c[u];
                    m_al[u] = m_c[u];
                    m_ac[u]++;
                end
                if (va[0])   m_a0l[u] = m_c[u];
                if (vb[c-1]) m_bl[u]  = m_c[u];
            end else begin
                m_drain[u]++;
            end
        end
        if (td) begin
            check(u, ev(2, tidx, m_xfer[u], m_comp[u], m_drain[u], m_lat[u], m_af[u],
                        m_al[u], m_ac[u], m_a0l[u], m_bl[u]), "tile_done");
            m_ntiles[u]++;
            clear_tile(u);
        end
        if (dn) check(u, ev(3, busy, tidx, m_ntiles[u], m_xfer[u], anyv, acc, 0, 0, 0, 0), "done");
        if (m_prev_busy[u] && !busy) begin
            check(u, ev(4, anyv, rd, td, dn, m_started[u] ? m_c[u] : 0, tidx, 0, 0, 0, 0),
                  "busy_fall");
            clear_tile(u);
        end
        m_prev_busy[u] = busy;
        if (m_started[u]) m_c[u]++;
        m_cyc[u]++;
    endtask

    always @(negedge clk) begin
        observe(0, bus0.busy, bus0.rd_req, bus0.data_valid, bus0.acc_clr, bus0.tile_done,
                bus0.done, bus0.valid_a, bus0.valid_b, bus0.tile_idx, bus0.state_dbg, 16, 16);
        observe(1, bus1.busy, bus1.rd_req, bus1.data_valid, bus1.acc_clr, bus1.tile_done,
                bus1.done, {12'b0, bus1.valid_a}, {8'b0, bus1.valid_b}, bus1.tile_idx,
                bus1.state_dbg, 4, 8);
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int u, input logic s, input logic [15:0] k,
                          input logic ab, input logic dv);
        if (u == 0) begin
            bus0.start = s; bus0.k_len = k; bus0.abort = ab; bus0.data_valid = dv;
        end else begin
            bus1.start = s; bus1.k_len = k; bus1.abort = ab; bus1.data_valid = dv;
        end
    endtask

    function automatic logic get_busy(input int u);
        return (u == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic job_end(input int u, input bit ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL job_end u%0d: busy still 1 after cycle budget, required 0", u);
        end
    endtask

    // mode 0: data_valid always 1; mode 1: data_valid pattern 1,0,0 repeating.
    task automatic run_job(input int u, input int k, input int mode);
        bit ok;
        ok = 0;
        step();
        set_in(u, 1'b1, 16'(k), 1'b0, 1'b1);
        step();
        for (int n = 0; n < 4000; n++) begin
            set_in(u, 1'b0, 16'(k), 1'b0, (mode == 0) ? 1'b1 : ((n % 3) == 0));
            if (!get_busy(u)) begin
                ok = 1;
                break;
            end
            step();
        end
        set_in(u, 1'b0, 16'(0), 1'b0, 1'b0);
        job_end(u, ok);
    endtask

    // Abort unit 0 while it is in COMPUTE cycle c of tile t.
    task automatic run_abort(input int k, input int t, input int c);
        bit found;
        found = 0;
        step();
        set_in(0, 1'b1, 16'(k), 1'b0, 1'b1);
        step();
        set_in(0, 1'b0, 16'(k), 1'b0, 1'b1);
        for (int n = 0; n < 4000; n++) begin
            if (bus0.tile_idx == 8'(t) && bus0.valid_a[0]) begin
                found = 1;
                break;
            end
            step();
        end
        if (found) begin
            repeat (c) step();
            bus0.abort = 1'b1;
            step();
            bus0.abort = 1'b0;
        end
        repeat (2) step();
        set_in(0, 1'b0, 16'(0), 1'b0, 1'b0);
        job_end(0, found && !bus0.busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 1'b0, 16'(0), 1'b0, 1'b0);
        set_in(1, 1'b0, 16'(0), 1'b0, 1'b0);
        exp_rst(0);
        exp_rst(1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // k=27: three full tiles of 9 beats.
        exp_acc(0);
        for (int t = 0; t < 3; t++) exp_tile(0, t, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_done(0, 2, 3, 0);
        exp_idle(0, 0, 2);
        run_job(0, 27, 0);

        // k=20: tiles of 9, 9, 2.
        exp_acc(0);
        exp_tile(0, 0, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_tile(0, 1, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_tile(0, 2, 2, 17, 31, 15, 16, 2, 1, 16);
        exp_done(0, 2, 3, 0);
        exp_idle(0, 0, 2);
        run_job(0, 20, 0);

        // k=9 with a stalling buffer.
        exp_acc(0);
        exp_tile(0, 0, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_done(0, 0, 1, 0);
        exp_idle(0, 0, 0);
        run_job(0, 9, 1);

        // k=0: clear and done together, nothing loaded.
        exp_acc(0);
        exp_done(0, 0, 0, 1);
        exp_idle(0, 0, 0);
        run_job(0, 0, 0);

        // Abort at c=5 of tile 1, then a clean k=9 job.
        exp_acc(0);
        exp_tile(0, 0, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_idle(0, 6, 0);
        run_abort(27, 1, 5);
        exp_acc(0);
        exp_tile(0, 0, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_done(0, 0, 1, 0);
        exp_idle(0, 0, 0);
        run_job(0, 9, 0);

        // Non-square 4x8 array, BUF_DEPTH 4.
        exp_acc(1);
        exp_tile(1, 0, 4, 11, 11, 3, 6, 4, 3, 10);
        exp_done(1, 0, 1, 0);
        exp_idle(1, 0, 0);
        run_job(1, 4, 0);
        exp_acc(1);
        exp_tile(1, 0, 4, 11, 11, 3, 6, 4, 3, 10);
        exp_tile(1, 1, 2, 9, 11, 3, 4, 2, 1, 8);
        exp_done(1, 1, 2, 0);
        exp_idle(1, 0, 1);
        run_job(1, 6, 0);

        // Reset mid-LOAD with start held during reset.
        exp_acc(0);
        exp_rst(0);
        exp_rst(1);
        step();
        set_in(0, 1'b1, 16'(27), 1'b0, 1'b1);
        step();
        set_in(0, 1'b0, 16'(27), 1'b0, 1'b1);
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        set_in(0, 1'b1, 16'(5), 1'b0, 1'b1);
        repeat (3) step();
        set_in(0, 1'b0, 16'(0), 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        exp_acc(0);
        exp_tile(0, 0, 9, 24, 31, 15, 23, 9, 8, 23);
        exp_done(0, 0, 1, 0);
        exp_idle(0, 0, 0);
        run_job(0, 9, 0);

        repeat (5) step();
        n_tests++;
        if (exp_q0.size() != 0) begin
            n_fail++;
            $display("FAIL leftover u0: %0d expected events not seen, required 0", exp_q0.size());
        end
        n_tests++;
        if (exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL leftover u1: %0d expected events not seen, required 0", exp_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
